// File: rtl/reaction_ctrl.sv
// reaction_ctrl: reaction-time game round sequencer (seed draw, random pre-delay, GO, ms timing).
// Optional: define BEST_SCORE_EN to keep the best (minimum) valid reaction time on best_ms.
module reaction_ctrl #(
  parameter int MIN_DELAY_MS = 1000,
  parameter int DELAY_SCALE  = 16,
  parameter int MAX_MS       = 9999,
  parameter int CW           = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_ms,
  input  logic          start_btn,
  input  logic          react_btn,
  input  logic [6:0]    lfsr_val,
  input  logic          lfsr_ready,
  output logic          lfsr_stop,
  output logic          led_go,
  output logic          busy,
  output logic [CW-1:0] rt_ms,
  output logic          rt_valid,
  output logic          too_early,
  output logic          timeout,
  output logic [CW-1:0] best_ms
);
  typedef enum logic [2:0] {IDLE, SEED, WAIT, GO, DONE, FAULT} state_t;
  localparam logic [CW-1:0] MAX    = CW'(MAX_MS);
  localparam logic [CW-1:0] MAX_M1 = CW'(MAX_MS - 1);
  localparam logic [15:0]   MIN    = 16'(MIN_DELAY_MS);
  localparam logic [15:0]   SCL    = 16'(DELAY_SCALE);
  state_t      state;
  logic        start_q, react_q;
  logic [15:0] cnt;
  logic        start_e, react_e;
  assign start_e = start_btn & ~start_q;
  assign react_e = react_btn & ~react_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      react_q   <= 1'b0;
      cnt       <= '0;
      lfsr_stop <= 1'b0;
      led_go    <= 1'b0;
      busy      <= 1'b0;
      rt_ms     <= '0;
      rt_valid  <= 1'b0;
      too_early <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      start_q <= start_btn;
      react_q <= react_btn;
      case (state)
        IDLE, DONE, FAULT: if (start_e) begin
          state     <= SEED;
          lfsr_stop <= 1'b1;
          busy      <= 1'b1;
          rt_valid  <= 1'b0;
          too_early <= 1'b0;
          timeout   <= 1'b0;
        end
        SEED: if (lfsr_ready) begin
          cnt       <= MIN + 16'(lfsr_val) * SCL;
          state     <= WAIT;
          lfsr_stop <= 1'b0;
        end
        // a false start wins over the final delay tick
        WAIT: if (react_e) begin
          state     <= FAULT;
          too_early <= 1'b1;
          busy      <= 1'b0;
        end else if (tick_ms) begin
          cnt <= cnt - 16'd1;
          if (cnt == 16'd1) begin
            state  <= GO;
            led_go <= 1'b1;
            rt_ms  <= '0;
          end
        end
        GO: if (react_e) begin
          state    <= DONE;
          rt_valid <= 1'b1;
          led_go   <= 1'b0;
          busy     <= 1'b0;
        end else if (tick_ms) begin
          if (rt_ms == MAX_M1) begin
            rt_ms   <= MAX;
            state   <= DONE;
            timeout <= 1'b1;
            led_go  <= 1'b0;
            busy    <= 1'b0;
          end else rt_ms <= rt_ms + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef BEST_SCORE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) best_ms <= '1;
    else if (state == GO && react_e && rt_ms < best_ms) best_ms <= rt_ms;
  end
`else
  assign best_ms = '0;
`endif
endmodule
